pp_pipeline_accel_frame_sink: RTL and testbench
===============================================

Name: pp_pipeline_accel_frame_sink

Overview:
- Consumer at the far end of the rows_c/cols_c scalar FIFOs filled by the pipeline entry process.
- Pops one rows/cols pair per ap_ctrl_chain invocation.
- Then drains exactly rows*cols pixels from the pixel FIFO onto an AXI4-Stream video output with SOF (tuser) and EOL (tlast), through a single registered output stage.

Parameters:
- PIX_W, 24, pixel data width.
- DIM_W, 16, dimension counter width; only the low DIM_W bits of each 32-bit dimension word are used.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- ap_start  in  1  start request
- ap_done  out  1  invocation complete; held until ap_continue
- ap_continue  in  1  acknowledges done
- ap_idle  out  1  high in IDLE with ap_start low
- ap_ready  out  1  one-cycle pulse when dimensions are consumed
- rows_c_dout  in  32  row count
- rows_c_num_data_valid  in  3  occupancy (unused)
- rows_c_fifo_cap  in  3  capacity (unused)
- rows_c_empty_n  in  1  rows FIFO not empty
- rows_c_read  out  1  pop rows FIFO
- cols_c_dout  in  32  column count
- cols_c_num_data_valid  in  3  occupancy (unused)
- cols_c_fifo_cap  in  3  capacity (unused)
- cols_c_empty_n  in  1  cols FIFO not empty
- cols_c_read  out  1  pop cols FIFO
- px_dout  in  PIX_W  pixel data
- px_empty_n  in  1  pixel FIFO not empty
- px_read  out  1  pop pixel FIFO
- out_tdata  out  PIX_W  registered pixel
- out_tvalid  out  1  output valid
- out_tready  in  1  downstream ready
- out_tuser  out  1  first pixel of frame
- out_tlast  out  1  last pixel of row

Behaviour:
- Reset values, applied on the first ap_clk edge with ap_rst=1:
  - state=IDLE; ap_done_reg=0; all counters 0; out_tvalid/tuser/tlast=0.
  - rows_c_read, cols_c_read and px_read are 0 during reset.
  - A frame in progress is abandoned; no partial-frame recovery.
- FSM states: IDLE, DIM, STREAM, DRAIN, DONE.
- IDLE:
  - Advances to DIM when ap_start=1 and ap_done_reg=0.
  - The transition can happen in the same cycle that ap_continue clears ap_done_reg.
- DIM:
  - When rows_c_empty_n & cols_c_empty_n, pulse rows_c_read, cols_c_read and ap_ready for exactly 1 cycle, all together.
  - Latch rows_c_dout[DIM_W-1:0] and cols_c_dout[DIM_W-1:0].
  - Never pop one FIFO without the other.
  - If either latched value is 0, go to DONE with no output beats. Otherwise clear row/col counters and go to STREAM.
- STREAM:
  - px_read = px_empty_n & (~out_tvalid | out_tready). This gives full throughput of 1 beat/cycle.
  - On each pop, load the output register:
    - tdata = px_dout.
    - tuser = (row==0 & col==0).
    - tlast = (col==cols-1).
  - Counter update: col increments; on col==cols-1, col wraps to 0 and row increments.
  - The pop of pixel (rows-1, cols-1) moves the FSM to DRAIN.
- Output register:
  - out_tvalid clears on out_tready with no new pop.
  - tdata/tuser/tlast hold stable while out_tvalid & ~out_tready.
- DRAIN: no px_read; wait for out_tvalid & out_tready, then go to DONE.
- DONE:
  - ap_done=1 combinationally on entry and registered in ap_done_reg until ap_continue=1.
  - Then go to IDLE, or directly to DIM if ap_start=1 in that cycle.
- Latency:
  - First beat appears on out_tvalid 1 cycle after its px_read.
  - ap_done rises the cycle after the last handshake.
- Width rules:
  - Counters are DIM_W bits. The comparison cols-1 is computed in DIM_W bits and is safe because zero is excluded beforehand.
  - Maximum frame is (2^DIM_W-1)^2.
- Boundary cases:
  - Pixel FIFO empty mid-frame: stall, out_tvalid drops once the last beat is accepted.
  - out_tready low: no pops, so the pixel FIFO backs up upstream.
  - cols=1: every beat has tlast=1.
  - rows=1, cols=1: a single beat with tuser=tlast=1.

Decomposition:
- Package pp_pipeline_accel_frame_sink_pkg holds:
  - the state enum (5 states, binary encoded);
  - DIM_W_DEFAULT and PIX_W_DEFAULT.
- One sub-module, pp_pipeline_accel_axis_reg: a 1-deep valid/ready output register carrying {tuser, tlast, tdata}.
- FSM and counters stay in the top module.

Test Plan:
- rows=2, cols=3, pixels 0x01..0x06, tready=1 -> 6 beats in order; tuser only on 0x01; tlast on 0x03 and 0x06; 1 ap_ready pulse; ap_done 1 cycle after beat 6.
- rows=0, cols=5 -> both FIFOs popped once; ap_ready then ap_done; 0 beats and 0 px_read.
- rows=1, cols=1 pixel 0xABCDEF with tready low 4 cycles -> tdata/tuser=1/tlast=1 held for all 4 cycles; single handshake; then done.
- rows=4, cols=4 with random px_empty_n and out_tready gaps -> exactly 16 beats, tlast every 4th, no duplicated or dropped pixels.
- ap_continue held low 10 cycles after done with ap_start high -> ap_done stays 1 and no DIM reads. Continue=1 -> next dims read on the following cycle.
- ap_rst pulse after beat 5 of a 3x3 frame -> out_tvalid=0 next cycle and FSM in IDLE. New 2x2 frame completes with tuser on its first beat.

Source files
------------

// File: rtl/pp_pipeline_accel_frame_sink_pkg.sv
// pp_pipeline_accel_frame_sink_pkg: shared state encoding and default widths
// for the frame sink.
`default_nettype none

package pp_pipeline_accel_frame_sink_pkg;

    localparam int unsigned PIX_W_DEFAULT = 24;
    localparam int unsigned DIM_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pp_pipeline_accel_axis_reg.sv
// pp_pipeline_accel_axis_reg: one-deep valid/ready output register; the
// payload only changes on load, so it holds stable while stalled.
`default_nettype none

module pp_pipeline_accel_axis_reg #(
    parameter int unsigned W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // The producer only asserts load_i when the slot is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pp_pipeline_accel_frame_sink.sv
// pp_pipeline_accel_frame_sink: pops one rows/cols pair per ap_ctrl_chain call
// and streams rows*cols pixels out as AXI4-Stream video with SOF/EOL.
`default_nettype none

module pp_pipeline_accel_frame_sink
    import pp_pipeline_accel_frame_sink_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT,
    parameter int unsigned DIM_W = DIM_W_DEFAULT
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    input  logic             ap_continue,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [31:0]      rows_c_dout,
    input  logic [2:0]       rows_c_num_data_valid,
    input  logic [2:0]       rows_c_fifo_cap,
    input  logic             rows_c_empty_n,
    output logic             rows_c_read,
    input  logic [31:0]      cols_c_dout,
    input  logic [2:0]       cols_c_num_data_valid,
    input  logic [2:0]       cols_c_fifo_cap,
    input  logic             cols_c_empty_n,
    output logic             cols_c_read,
    input  logic [PIX_W-1:0] px_dout,
    input  logic             px_empty_n,
    output logic             px_read,
    output logic [PIX_W-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tuser,
    output logic             out_tlast
);

    localparam logic [DIM_W-1:0] c_ONE = DIM_W'(1);

    state_e             state_q, state_d;
    logic               done_reg_q, done_reg_d;
    logic [DIM_W-1:0]   rows_q, rows_d;
    logic [DIM_W-1:0]   cols_q, cols_d;
    logic [DIM_W-1:0]   row_q, row_d;
    logic [DIM_W-1:0]   col_q, col_d;

    logic               w_pop_dims;
    logic               w_px_pop;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_first;
    logic [DIM_W-1:0]   w_rows_in;
    logic [DIM_W-1:0]   w_cols_in;
    logic [PIX_W+1:0]   w_reg_out;
    logic               w_unused;

    assign w_rows_in  = rows_c_dout[DIM_W-1:0];
    assign w_cols_in  = cols_c_dout[DIM_W-1:0];

    // Both dimension FIFOs are always popped together or not at all.
    assign w_pop_dims = (state_q == ST_DIM) & rows_c_empty_n & cols_c_empty_n & ~ap_rst;
    assign w_px_pop   = (state_q == ST_STREAM) & px_empty_n
                      & (~out_tvalid | out_tready) & ~ap_rst;

    // Zero dimensions never reach STREAM, so the minus-one cannot wrap.
    assign w_col_last = (col_q == cols_q - c_ONE);
    assign w_row_last = (row_q == rows_q - c_ONE);
    assign w_first    = (row_q == '0) & (col_q == '0);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            done_reg_q <= 1'b0;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_reg_q <= done_reg_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_reg_d = done_reg_q & ~ap_continue;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start & (~done_reg_q | ap_continue)) begin
                    state_d = ST_DIM;
                end
            end
            ST_DIM: begin
                if (w_pop_dims) begin
                    rows_d = w_rows_in;
                    cols_d = w_cols_in;
                    row_d  = '0;
                    col_d  = '0;
                    if ((w_rows_in == '0) | (w_cols_in == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (w_px_pop) begin
                    if (w_col_last) begin
                        col_d = '0;
                        row_d = row_q + c_ONE;
                        if (w_row_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + c_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_tvalid & out_tready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_reg_d = ~ap_continue;
                if (ap_continue) begin
                    state_d = ap_start ? ST_DIM : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    pp_pipeline_accel_axis_reg #(
        .W (PIX_W + 2)
    ) u_out_reg (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .load_i  (w_px_pop),
        .data_i  ({w_first, w_col_last, px_dout}),
        .ready_i (out_tready),
        .valid_o (out_tvalid),
        .data_o  (w_reg_out)
    );

    assign out_tuser   = w_reg_out[PIX_W+1];
    assign out_tlast   = w_reg_out[PIX_W];
    assign out_tdata   = w_reg_out[PIX_W-1:0];

    assign ap_done     = done_reg_q | (state_q == ST_DONE);
    assign ap_idle     = (state_q == ST_IDLE) & ~ap_start;
    assign ap_ready    = w_pop_dims;
    assign rows_c_read = w_pop_dims;
    assign cols_c_read = w_pop_dims;
    assign px_read     = w_px_pop;

    // Occupancy/capacity and the upper dimension bits are not needed here.
    assign w_unused = ^{rows_c_num_data_valid, rows_c_fifo_cap, rows_c_dout,
                        cols_c_num_data_valid, cols_c_fifo_cap, cols_c_dout};

endmodule

`default_nettype wire

// File: tb/tb_pp_pipeline_accel_frame_sink.sv
// tb_pp_pipeline_accel_frame_sink: randomized self-checking bench with queue
// FIFO models and an expected-beat list computed from the frame dimensions.
`timescale 1ns/1ps
`default_nettype none

module tb_pp_pipeline_accel_frame_sink;

    localparam int PIX_W = 24;
    localparam int DIM_W = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic             ap_start = 1'b0;
    logic             ap_continue = 1'b0;
    logic             ap_done, ap_idle, ap_ready;
    logic [31:0]      rows_c_dout = '0, cols_c_dout = '0;
    logic [2:0]       rows_nd = 3'd1, rows_cap = 3'd2, cols_nd = 3'd1, cols_cap = 3'd2;
    logic             rows_c_empty_n = 1'b0, cols_c_empty_n = 1'b0;
    logic             rows_c_read, cols_c_read;
    logic [PIX_W-1:0] px_dout = '0;
    logic             px_empty_n = 1'b0;
    logic             px_read;
    logic [PIX_W-1:0] out_tdata;
    logic             out_tvalid, out_tuser, out_tlast;
    logic             out_tready = 1'b1;

    pp_pipeline_accel_frame_sink #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ap_continue           (ap_continue),
        .ap_idle               (ap_idle),
        .ap_ready              (ap_ready),
        .rows_c_dout           (rows_c_dout),
        .rows_c_num_data_valid (rows_nd),
        .rows_c_fifo_cap       (rows_cap),
        .rows_c_empty_n        (rows_c_empty_n),
        .rows_c_read           (rows_c_read),
        .cols_c_dout           (cols_c_dout),
        .cols_c_num_data_valid (cols_nd),
        .cols_c_fifo_cap       (cols_cap),
        .cols_c_empty_n        (cols_c_empty_n),
        .cols_c_read           (cols_c_read),
        .px_dout               (px_dout),
        .px_empty_n            (px_empty_n),
        .px_read               (px_read),
        .out_tdata             (out_tdata),
        .out_tvalid            (out_tvalid),
        .out_tready            (out_tready),
        .out_tuser             (out_tuser),
        .out_tlast             (out_tlast)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [PIX_W-1:0] d;
        logic             u;
        logic             l;
        int               cyc;
    } beat_t;

    logic [31:0]      rq[$];
    logic [31:0]      cq[$];
    logic [PIX_W-1:0] pq[$];
    beat_t            rcv[$];
    beat_t            exp_q[$];

    int  cyc = 0, n_px_read = 0, n_rows_read = 0, n_cols_read = 0, n_ready = 0, n_split = 0;
    int  last_hs_cyc = 0, done_rise_cyc = 0;
    logic prev_done = 1'b0;
    bit  pend_px = 0, pend_rows = 0, pend_cols = 0;
    int  tready_mode = 1;
    bit  stall_en = 0;
    int  n_checks = 0, n_fail = 0;

    // Monitor: samples mid-cycle; every strobe seen here takes effect at the next posedge.
    always @(negedge ap_clk) begin
        #2;
        cyc++;
        pend_px   = px_read;
        pend_rows = rows_c_read;
        pend_cols = cols_c_read;
        if (px_read) n_px_read++;
        if (rows_c_read) n_rows_read++;
        if (cols_c_read) n_cols_read++;
        if (rows_c_read != cols_c_read) n_split++;
        if (ap_ready) n_ready++;
        if (out_tvalid && out_tready && !ap_rst) begin
            rcv.push_back('{d: out_tdata, u: out_tuser, l: out_tlast, cyc: cyc});
            last_hs_cyc = cyc;
        end
        if (ap_done && !prev_done) done_rise_cyc = cyc;
        prev_done = ap_done;
    end

    // FIFO / sink driver: applies pops, then presents the new heads.
    always @(posedge ap_clk) begin
        #1;
        if (pend_px && pq.size() > 0) void'(pq.pop_front());
        if (pend_rows && rq.size() > 0) void'(rq.pop_front());
        if (pend_cols && cq.size() > 0) void'(cq.pop_front());
        rows_c_empty_n = (rq.size() > 0);
        rows_c_dout    = (rq.size() > 0) ? rq[0] : 32'd0;
        cols_c_empty_n = (cq.size() > 0);
        cols_c_dout    = (cq.size() > 0) ? cq[0] : 32'd0;
        px_empty_n     = (pq.size() > 0) && (!stall_en || ($urandom_range(0, 2) != 0));
        px_dout        = (pq.size() > 0) ? pq[0] : '0;
        case (tready_mode)
            0:       out_tready = 1'b0;
            1:       out_tready = 1'b1;
            default: out_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic push_frame(input logic [31:0] r, input logic [31:0] c,
                              input bit rnd, input logic [PIX_W-1:0] base);
        logic [DIM_W-1:0] rr, cc;
        logic [PIX_W-1:0] p;
        int n;
        rr = r[DIM_W-1:0];
        cc = c[DIM_W-1:0];
        rq.push_back(r);
        cq.push_back(c);
        n = int'(rr) * int'(cc);
        for (int i = 0; i < n; i++) begin
            p = rnd ? PIX_W'($urandom) : base + PIX_W'(i);
            pq.push_back(p);
            exp_q.push_back('{d: p, u: (i == 0), l: ((i % int'(cc)) == int'(cc) - 1), cyc: 0});
        end
    endtask

    task automatic start_dims(output bit ok);
        ok = 0;
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (ap_ready) begin
                ok = 1;
                break;
            end
        end
        ap_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                ok = 1;
                break;
            end
        end
        #3;
    endtask

    task automatic ack_done();
        ap_continue = 1'b1;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        n_checks++;
        if ({rows_c_read, cols_c_read, px_read, ap_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_reads: got %b, expected 0000", {rows_c_read, cols_c_read, px_read, ap_ready});
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        n_checks++;
        if ({out_tvalid, out_tuser, out_tlast, ap_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000", {out_tvalid, out_tuser, out_tlast, ap_done});
        end
        n_checks++;
        if (ap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got %b, expected 1", ap_idle);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int ready0 = n_ready, px0 = n_px_read;
        rcv.delete(); exp_q.delete();
        tready_mode = 1; stall_en = 0;
        push_frame(32'd2, 32'd3, 0, 24'h000001);
        start_dims(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_start: got no ap_ready, expected one"); end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done: got no ap_done, expected one"); end
        n_checks++;
        if (rcv.size() !== 6) begin n_fail++; $display("FAIL basic_count: got %0d beats, expected 6", rcv.size()); end
        for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rcv[i].d !== exp_q[i].d || rcv[i].u !== exp_q[i].u || rcv[i].l !== exp_q[i].l) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                         i, rcv[i].d, rcv[i].u, rcv[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
            n_checks++;
            if (rcv[i].cyc !== rcv[0].cyc + i) begin
                n_fail++;
                $display("FAIL basic_rate%0d: got cycle %0d, expected %0d", i, rcv[i].cyc, rcv[0].cyc + i);
            end
        end
        n_checks++;
        if (done_rise_cyc !== last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done_lat: got cycle %0d, expected %0d", done_rise_cyc, last_hs_cyc + 1);
        end
        n_checks++;
        if (n_ready - ready0 !== 1 || n_px_read - px0 !== 6) begin
            n_fail++;
            $display("FAIL basic_counts: got ready=%0d px_read=%0d, expected 1 and 6", n_ready - ready0, n_px_read - px0);
        end
        ack_done();
    endtask

    task automatic test_zero_dim();
        bit ok;
        int ready0 = n_ready, px0 = n_px_read, r0 = n_rows_read, c0 = n_cols_read, s0 = n_split;
        rcv.delete(); exp_q.delete();
        push_frame(32'hABCD_0000, 32'd5, 1, '0);
        pq.push_back(24'h111111);
        pq.push_back(24'h222222);
        start_dims(ok);
        wait_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL zero_done: got no ap_done, expected one"); end
        n_checks++;
        if (n_rows_read - r0 !== 1 || n_cols_read - c0 !== 1 || n_split !== s0) begin
            n_fail++;
            $display("FAIL zero_pops: got rows=%0d cols=%0d split=%0d, expected 1 1 0",
                     n_rows_read - r0, n_cols_read - c0, n_split - s0);
        end
        n_checks++;
        if (n_ready - ready0 !== 1 || rcv.size() !== 0 || n_px_read - px0 !== 0 || pq.size() !== 2) begin
            n_fail++;
            $display("FAIL zero_stream: got ready=%0d beats=%0d px_read=%0d left=%0d, expected 1 0 0 2",
                     n_ready - ready0, rcv.size(), n_px_read - px0, pq.size());
        end
        ack_done();
        pq.delete();
        repeat (2) @(negedge ap_clk);
    endtask

    task automatic test_single_hold();
        bit ok;
        rcv.delete(); exp_q.delete();
        tready_mode = 0;
        push_frame(32'd1, 32'd1, 0, 24'hABCDEF);
        start_dims(ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_tvalid) begin ok = 1; break; end
            @(negedge ap_clk);
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL hold_valid: got no out_tvalid, expected one"); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({out_tvalid, out_tuser, out_tlast} !== 3'b111 || out_tdata !== 24'hABCDEF) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v/u/l=%b d=%h, expected 111 d=abcdef",
                         k, {out_tvalid, out_tuser, out_tlast}, out_tdata);
            end
            if (k == 3) tready_mode = 1;
            @(negedge ap_clk);
        end
        wait_done(50, ok);
        n_checks++;
        if (!ok || rcv.size() !== 1) begin
            n_fail++;
            $display("FAIL hold_done: got done=%b beats=%0d, expected 1 and 1", ok, rcv.size());
        end else begin
            n_checks++;
            if (rcv[0].d !== 24'hABCDEF || rcv[0].u !== 1'b1 || rcv[0].l !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_beat: got d=%h u=%b l=%b, expected abcdef 1 1", rcv[0].d, rcv[0].u, rcv[0].l);
            end
        end
        ack_done();
    endtask

    task automatic test_random_gaps();
        bit ok;
        logic [31:0] r, c;
        for (int f = 0; f < 3; f++) begin
            rcv.delete(); exp_q.delete();
            stall_en = 1; tready_mode = 2;
            r = (f == 0) ? 32'd4 : 32'($urandom_range(1, 4));
            c = (f == 0) ? 32'd4 : ((f == 1) ? 32'd1 : 32'($urandom_range(2, 6)));
            push_frame(r, c, 1, '0);
            start_dims(ok);
            wait_done(2000, ok);
            n_checks++;
            if (!ok || rcv.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL gaps%0d_count: got done=%b beats=%0d, expected 1 and %0d", f, ok, rcv.size(), exp_q.size());
            end
            for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (rcv[i].d !== exp_q[i].d || rcv[i].u !== exp_q[i].u || rcv[i].l !== exp_q[i].l) begin
                    n_fail++;
                    $display("FAIL gaps%0d_beat%0d: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                             f, i, rcv[i].d, rcv[i].u, rcv[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
                end
            end
            ack_done();
        end
        stall_en = 0; tready_mode = 1;
    endtask

    task automatic test_continue_hold();
        bit ok;
        int r0;
        rcv.delete(); exp_q.delete();
        push_frame(32'd1, 32'd2, 1, '0);
        push_frame(32'd1, 32'd1, 1, '0);
        start_dims(ok);
        wait_done(100, ok);
        ap_start = 1'b1;
        r0 = n_rows_read;
        for (int k = 0; k < 10; k++) begin
            @(negedge ap_clk);
            n_checks++;
            if (ap_done !== 1'b1 || rows_c_read !== 1'b0 || n_rows_read !== r0) begin
                n_fail++;
                $display("FAIL cont_hold%0d: got done=%b read=%b pops=%0d, expected 1 0 0",
                         k, ap_done, rows_c_read, n_rows_read - r0);
            end
        end
        ap_continue = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (rows_c_read !== 1'b1 || ap_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_restart: got read=%b ready=%b, expected 1 1", rows_c_read, ap_ready);
        end
        ap_continue = 1'b0;
        ap_start = 1'b0;
        wait_done(100, ok);
        n_checks++;
        if (!ok || rcv.size() !== 3) begin
            n_fail++;
            $display("FAIL cont_count: got done=%b beats=%0d, expected 1 and 3", ok, rcv.size());
        end
        for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rcv[i].d !== exp_q[i].d || rcv[i].u !== exp_q[i].u || rcv[i].l !== exp_q[i].l) begin
                n_fail++;
                $display("FAIL cont_beat%0d: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                         i, rcv[i].d, rcv[i].u, rcv[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        ack_done();
    endtask

    task automatic test_reset_midframe();
        bit ok;
        rcv.delete(); exp_q.delete();
        push_frame(32'd3, 32'd3, 1, '0);
        start_dims(ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (rcv.size() >= 5) begin ok = 1; break; end
            @(negedge ap_clk);
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_beats: got %0d beats, expected 5", rcv.size()); end
        ap_rst = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (out_tvalid !== 1'b0 || ap_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: got valid=%b idle=%b, expected 0 1", out_tvalid, ap_idle);
        end
        ap_rst = 1'b0;
        pq.delete(); rq.delete(); cq.delete();
        repeat (2) @(negedge ap_clk);
        rcv.delete(); exp_q.delete();
        push_frame(32'd2, 32'd2, 1, '0);
        start_dims(ok);
        wait_done(100, ok);
        n_checks++;
        if (!ok || rcv.size() !== 4) begin
            n_fail++;
            $display("FAIL rstmid_count: got done=%b beats=%0d, expected 1 and 4", ok, rcv.size());
        end
        for (int i = 0; i < rcv.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rcv[i].d !== exp_q[i].d || rcv[i].u !== exp_q[i].u || rcv[i].l !== exp_q[i].l) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: got d=%h u=%b l=%b, expected d=%h u=%b l=%b",
                         i, rcv[i].d, rcv[i].u, rcv[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        ack_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_dim();
        test_single_hold();
        test_random_gaps();
        test_continue_hold();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
